alu16_seq: RTL and testbench
============================

ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 SHALL have one clock, `clock`, and one reset, `reset`; `reset` is synchronous and active-high.
REQ-002 Ports, in order (name, direction, width, meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  request strobe, sampled in IDLE only
- op  in  2  operation: 0 ADD16 (ADD HL,rr), 1 INC16, 2 DEC16, 3 ADDSP (ADD SP,e8)
- a_in  16  in  first operand (HL, rr or SP)
- b_in  16  in  second operand; ADDSP uses b_in[7:0] as signed e8
- flags_in  in  4  current ZNHC
- busy  out  1  high in LOW and HIGH states
- done  out  1  one-cycle completion pulse
- result  out  16  16-bit result
- flags_out  out  4  final ZNHC
- alu_op  out  5  ALU opcode, cpu.vh encodings
- alu_data0  out  8  ALU operand 0
- alu_data1  out  8  ALU operand 1
- alu_flags  out  4  flags presented to the ALU
- alu_size  out  1  ALU_SIZE_8 or ALU_SIZE_16
- alu_data_in  in  8  ALU result
- alu_flags_in  in  4  ALU result flags

Function
REQ-003 SHALL implement states IDLE, LOW, HIGH, DONE; transitions are IDLE->LOW on start, LOW->HIGH, HIGH->DONE, DONE->IDLE unconditionally.
REQ-004 On start in IDLE, SHALL capture op, a_in, b_in and flags_in; later input changes have no effect until the next accept.
REQ-005 SHALL ignore start in LOW, HIGH and DONE; no queueing.
REQ-006 Latency: start sampled at edge T -> done=1 during cycle T+3 for exactly one cycle.
REQ-007 In IDLE and DONE, SHALL drive alu_op=ALU_PASS0, alu_data0=alu_data1=0, alu_flags=captured flags, alu_size=ALU_SIZE_8.
REQ-008 LOW state: alu_data1=a[7:0], alu_size=ALU_SIZE_16, alu_flags=captured flags; ALU_ADD with data0=b[7:0] for ADD16/ADDSP; ALU_ADD with data0=1 for INC16; ALU_SUB with data0=1 for DEC16.
REQ-009 At LOW exit, SHALL register alu_data_in as result low byte and alu_flags_in as the low flags.
REQ-010 HIGH state: alu_data1=a[15:8], alu_size=ALU_SIZE_16, alu_flags={captured Z, 0, 0, low C}; ALU_ADC with data0=b[15:8] (ADD16), 8'h00 (INC16), or {8{b[7]}} (ADDSP); ALU_SBC with data0=8'h00 (DEC16).
REQ-011 At HIGH exit, SHALL register result high byte and the high flags.
REQ-012 Final flags, ZNHC:
- ADD16 = {captured Z, 0, high H, high C}
- INC16/DEC16 = captured flags unchanged
- ADDSP = {0, 0, low H, low C}
REQ-013 result and flags_out SHALL update together at DONE entry and hold until the next DONE entry or reset.
REQ-014 Arithmetic SHALL wrap modulo 2^16 with no overflow indication beyond C.

Reset
REQ-015 reset=1 at any edge, including mid-operation, SHALL force IDLE, busy=0, done=0, result=16'h0000, flags_out=4'h0, and clear captured operands.
REQ-016 If start and reset are both high, reset wins; the start is discarded.

Verification
REQ-017 ADD16 a=0x0FFF b=0x0001 flags_in=1000 -> result 0x1000, flags_out=1010, done at T+3, busy high T+1..T+2.
REQ-018 ADD16 a=0xFFFF b=0x0001 flags_in=0000 -> result 0x0000, flags_out=0011 (Z preserved, not computed).
REQ-019 INC16 a=0x00FF flags_in=0101 -> 0x0100, flags_out 0101; DEC16 a=0x0000 flags_in=1010 -> 0xFFFF, flags_out 1010.
REQ-020 ADDSP a=0xFFF8 e=0x08 flags_in=1111 -> 0x0000, flags_out 0011; ADDSP a=0x0000 e=0xFF -> 0xFFFF, flags_out 0000.
REQ-021 start during LOW with different operands -> ignored, first result unchanged; reset asserted in HIGH -> next cycle busy=0, done=0, result 0x0000, no done pulse follows.
REQ-022 Back-to-back: start held high continuously -> accepts every 4 cycles (IDLE, LOW, HIGH, DONE), one done pulse per accept.

Source files
------------

// File: rtl/alu16_seq.sv
// alu16_seq: runs a 16-bit ADD HL,rr / INC16 / DEC16 / ADD SP,e8 operation
// through a shared 8-bit ALU in two passes: the low byte, then the high byte with carry.
// Ports:
//   clock, reset                 system clock and synchronous active-high reset
//   start, op, a_in, b_in,       request; inputs are captured when the request is accepted
//   flags_in
//   busy, done, result,          status and 16-bit result with final ZNHC flags
//   flags_out
//   alu_op, alu_data0,           drive the external 8-bit ALU
//   alu_data1, alu_flags,
//   alu_size
//   alu_data_in, alu_flags_in    byte result and flags returned by the ALU
module alu16_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [3:0]  flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags_out,
    output logic [4:0]  alu_op,
    output logic [7:0]  alu_data0,
    output logic [7:0]  alu_data1,
    output logic [3:0]  alu_flags,
    output logic        alu_size,
    input  logic [7:0]  alu_data_in,
    input  logic [3:0]  alu_flags_in
);

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_ADC   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_SBC   = 5'd3;
    localparam logic [4:0] ALU_PASS0 = 5'd16;

    localparam logic ALU_SIZE_8  = 1'b0;
    localparam logic ALU_SIZE_16 = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] OP_ADD16 = 2'd0;
    localparam logic [1:0] OP_INC16 = 2'd1;
    localparam logic [1:0] OP_DEC16 = 2'd2;
    localparam logic [1:0] OP_ADDSP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  f_q;
    logic [7:0]  lo_byte;
    logic [1:0]  lo_hc;
    logic [3:0]  final_flags;

    // Z and N returned by the ALU are never used: Z is carried over from
    // the captured flags and N is always cleared for these operations.
    logic unused_alu_zn;
    assign unused_alu_zn = ^alu_flags_in[3:2];

    assign busy = (state == ST_LOW) || (state == ST_HIGH);
    assign done = (state == ST_DONE);

    // Final ZNHC, evaluated while the high-byte pass is on the ALU.
    always_comb begin
        final_flags = f_q;
        case (op_q)
            OP_ADD16: final_flags = {f_q[3], 1'b0, alu_flags_in[1:0]};
            OP_ADDSP: final_flags = {2'b00, lo_hc};
            default:  final_flags = f_q;
        endcase
    end

    always_comb begin
        alu_op    = ALU_PASS0;
        alu_data0 = 8'h00;
        alu_data1 = 8'h00;
        alu_flags = f_q;
        alu_size  = ALU_SIZE_8;
        case (state)
            ST_LOW: begin
                alu_data1 = a_q[7:0];
                alu_size  = ALU_SIZE_16;
                case (op_q)
                    OP_INC16: begin
                        alu_op    = ALU_ADD;
                        alu_data0 = 8'h01;
                    end
                    OP_DEC16: begin
                        alu_op    = ALU_SUB;
                        alu_data0 = 8'h01;
                    end
                    default: begin
                        alu_op    = ALU_ADD;
                        alu_data0 = b_q[7:0];
                    end
                endcase
            end
            ST_HIGH: begin
                alu_data1 = a_q[15:8];
                alu_size  = ALU_SIZE_16;
                // Only the low-byte carry feeds the high pass.
                alu_flags = {f_q[3], 2'b00, lo_hc[0]};
                case (op_q)
                    OP_ADD16: begin
                        alu_op    = ALU_ADC;
                        alu_data0 = b_q[15:8];
                    end
                    OP_INC16: begin
                        alu_op    = ALU_ADC;
                        alu_data0 = 8'h00;
                    end
                    OP_DEC16: begin
                        alu_op    = ALU_SBC;
                        alu_data0 = 8'h00;
                    end
                    default: begin
                        // Sign-extend e8 into the high byte.
                        alu_op    = ALU_ADC;
                        alu_data0 = {8{b_q[7]}};
                    end
                endcase
            end
            default: begin
                alu_op    = ALU_PASS0;
                alu_data0 = 8'h00;
                alu_data1 = 8'h00;
                alu_flags = f_q;
                alu_size  = ALU_SIZE_8;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= 2'd0;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            f_q       <= 4'h0;
            lo_byte   <= 8'h00;
            lo_hc     <= 2'b00;
            result    <= 16'h0000;
            flags_out <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a_in;
                        b_q   <= b_in;
                        f_q   <= flags_in;
                        state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    lo_byte <= alu_data_in;
                    lo_hc   <= alu_flags_in[1:0];
                    state   <= ST_HIGH;
                end
                ST_HIGH: begin
                    result    <= {alu_data_in, lo_byte};
                    flags_out <= final_flags;
                    state     <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: drives alu16_seq with directed and random requests,
// emulates the external 8-bit ALU and checks against a 16-bit arithmetic model.
module tb_alu16_seq;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_ADC   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_SBC   = 5'd3;
    localparam logic [4:0] ALU_PASS0 = 5'd16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] a_in = 16'h0;
    logic [15:0] b_in = 16'h0;
    logic [3:0]  flags_in = 4'h0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags_out;
    logic [4:0]  alu_op;
    logic [7:0]  alu_data0;
    logic [7:0]  alu_data1;
    logic [3:0]  alu_flags;
    logic        alu_size;
    logic [7:0]  alu_data_in;
    logic [3:0]  alu_flags_in;

    int checks = 0;
    int failures = 0;

    alu16_seq dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .op(op),
        .a_in(a_in),
        .b_in(b_in),
        .flags_in(flags_in),
        .busy(busy),
        .done(done),
        .result(result),
        .flags_out(flags_out),
        .alu_op(alu_op),
        .alu_data0(alu_data0),
        .alu_data1(alu_data1),
        .alu_flags(alu_flags),
        .alu_size(alu_size),
        .alu_data_in(alu_data_in),
        .alu_flags_in(alu_flags_in)
    );

    always #5 clock = ~clock;

    // External 8-bit ALU: data1 is the accumulator side, data0 the operand.
    logic       cin;
    logic [8:0] sum9;
    logic [4:0] nib5;
    always_comb begin
        cin          = ((alu_op == ALU_ADC) || (alu_op == ALU_SBC)) ? alu_flags[0] : 1'b0;
        sum9         = 9'h0;
        nib5         = 5'h0;
        alu_data_in  = alu_data0;
        alu_flags_in = alu_flags;
        if ((alu_op == ALU_ADD) || (alu_op == ALU_ADC)) begin
            sum9         = {1'b0, alu_data1} + {1'b0, alu_data0} + {8'h00, cin};
            nib5         = {1'b0, alu_data1[3:0]} + {1'b0, alu_data0[3:0]} + {4'h0, cin};
            alu_data_in  = sum9[7:0];
            alu_flags_in = {sum9[7:0] == 8'h00, 1'b0, nib5[4], sum9[8]};
        end else if ((alu_op == ALU_SUB) || (alu_op == ALU_SBC)) begin
            sum9         = {1'b0, alu_data1} - {1'b0, alu_data0} - {8'h00, cin};
            nib5         = {1'b0, alu_data1[3:0]} - {1'b0, alu_data0[3:0]} - {4'h0, cin};
            alu_data_in  = sum9[7:0];
            alu_flags_in = {sum9[7:0] == 8'h00, 1'b1, nib5[4], sum9[8]};
        end
    end

    // Whole-word reference: returns {flags, result}.
    function automatic logic [19:0] ref16(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] f);
        int s;
        int e;
        logic h;
        logic c;
        logic [3:0] fo;
        s  = 0;
        fo = f;
        case (o)
            2'd0: begin
                s  = int'(a) + int'(b);
                h  = (int'(a[11:0]) + int'(b[11:0])) > 4095;
                c  = s > 65535;
                fo = {f[3], 1'b0, h, c};
            end
            2'd1: s = int'(a) + 1;
            2'd2: s = int'(a) - 1;
            default: begin
                e  = int'($signed(b[7:0]));
                s  = int'(a) + e;
                h  = (int'(a[3:0]) + int'(b[3:0])) > 15;
                c  = (int'(a[7:0]) + int'(b[7:0])) > 255;
                fo = {2'b00, h, c};
            end
        endcase
        return {fo, s[15:0]};
    endfunction

    // Model state: 0 idle, 1 low pass, 2 high pass, 3 completion cycle.
    int          ph = 0;
    bit          chk_en = 0;
    logic [1:0]  m_op = 2'd0;
    logic [15:0] m_a = 16'h0;
    logic [3:0]  m_f = 4'h0;
    logic [19:0] m_pend = 20'h0;
    logic [15:0] m_res = 16'h0;
    logic [3:0]  m_flg = 4'h0;

    always @(posedge clock) begin
        if (reset) begin
            ph     = 0;
            m_op   = 2'd0;
            m_a    = 16'h0;
            m_f    = 4'h0;
            m_res  = 16'h0;
            m_flg  = 4'h0;
            chk_en = 1;
        end else if (ph == 0) begin
            if (start) begin
                m_op   = op;
                m_a    = a_in;
                m_f    = flags_in;
                m_pend = ref16(op, a_in, b_in, flags_in);
                ph     = 1;
            end
        end else if (ph == 1) begin
            ph = 2;
        end else if (ph == 2) begin
            m_res = m_pend[15:0];
            m_flg = m_pend[19:16];
            ph    = 3;
        end else begin
            ph = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", busy, (ph == 1 || ph == 2));
            chk("done", done, (ph == 3));
            chk("result", result, m_res);
            chk("flags_out", flags_out, m_flg);
            if (ph == 0 || ph == 3) begin
                chk("idle_alu_op", alu_op, ALU_PASS0);
                chk("idle_alu_data", {alu_data0, alu_data1}, 16'h0);
                chk("idle_alu_size", alu_size, 1'b0);
                chk("idle_alu_flags", alu_flags, m_f);
            end else if (ph == 1) begin
                chk("low_op", alu_op, (m_op == 2'd2) ? ALU_SUB : ALU_ADD);
                chk("low_data1", alu_data1, m_a[7:0]);
                chk("low_size", alu_size, 1'b1);
            end else begin
                chk("high_op", alu_op, (m_op == 2'd2) ? ALU_SBC : ALU_ADC);
                chk("high_data1", alu_data1, m_a[15:8]);
                chk("high_size", alu_size, 1'b1);
            end
        end
    end

    task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] f,
                          input logic [15:0] er, input logic [3:0] ef);
        int n;
        @(negedge clock);
        start    = 1'b1;
        op       = o;
        a_in     = a;
        b_in     = b;
        flags_in = f;
        @(negedge clock);
        start    = 1'b0;
        op       = 2'($urandom);
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
        flags_in = 4'($urandom);
        n = 1;
        while (!done && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_latency"}, n, 3);
        chk({nm, "_res"}, result, er);
        chk({nm, "_flg"}, flags_out, ef);
        chk({nm, "_model"}, {m_flg, m_res}, {ef, er});
    endtask

    initial begin
        int n;
        int dones;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 16'h0);
        chk("rst_flags", flags_out, 4'h0);
        reset = 1'b0;

        run_op("add_h",   2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
        run_op("add_c",   2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
        run_op("inc",     2'd1, 16'h00FF, 16'h1234, 4'b0101, 16'h0100, 4'b0101);
        run_op("dec",     2'd2, 16'h0000, 16'h4321, 4'b1010, 16'hFFFF, 4'b1010);
        run_op("addsp_p", 2'd3, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011);
        run_op("addsp_n", 2'd3, 16'h0000, 16'h00FF, 4'b1111, 16'hFFFF, 4'b0000);

        // Start while busy must be dropped.
        @(negedge clock);
        start = 1'b1; op = 2'd0; a_in = 16'h1234; b_in = 16'h0101; flags_in = 4'h0;
        @(negedge clock);
        op = 2'd2; a_in = 16'h5555; b_in = 16'hAAAA; flags_in = 4'hF;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("ign_done", done, 1'b1);
        chk("ign_res", result, 16'h1335);
        chk("ign_flg", flags_out, 4'b0000);
        @(negedge clock);
        chk("ign_noreq", busy, 1'b0);

        // Reset during the high pass.
        start = 1'b1; op = 2'd0; a_in = 16'h7777; b_in = 16'h1111;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rsth_busy", busy, 1'b0);
        chk("rsth_done", done, 1'b0);
        chk("rsth_res", result, 16'h0);
        dones = 0;
        repeat (5) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("rsth_nodone", dones, 0);

        // Reset beats a simultaneous start.
        start = 1'b1; reset = 1'b1;
        @(negedge clock);
        start = 1'b0; reset = 1'b0;
        chk("rst_vs_start", busy, 1'b0);
        repeat (3) @(negedge clock);

        // Start held high: one accept every four cycles.
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            op       = 2'($urandom);
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
            flags_in = 4'($urandom);
            @(negedge clock);
            if (done) dones++;
        end
        start = 1'b0;
        chk("b2b_dones", dones, 4);
        repeat (4) @(negedge clock);

        // Random traffic including occasional resets.
        for (int i = 0; i < 2000; i++) begin
            start    = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 60) == 0);
            op       = 2'($urandom);
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
            flags_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) a_in = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) b_in = 16'h00FF;
            @(negedge clock);
        end
        start = 1'b0;
        reset = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("drain", busy, 1'b0);
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
